// File: rtl/lc3_dmem_responder_if.sv
// Request/response bundle between the LC3 pipeline controller and the data-memory responder.
// The master drives requests; the slave returns completion and read data.
interface lc3_dmem_responder_if;
    logic        D_macc;
    logic [1:0]  mem_state;
    logic [15:0] D_addr;
    logic [15:0] D_Din;
    logic [15:0] D_Dout;
    logic        complete_data;
    logic        busy;

    modport master (
        output D_macc, mem_state, D_addr, D_Din,
        input  D_Dout, complete_data, busy
    );

    modport slave (
        input  D_macc, mem_state, D_addr, D_Din,
        output D_Dout, complete_data, busy
    );
endinterface

// File: rtl/lc3_dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed latency,
// performs the access on an internal word array and pulses complete_data for one cycle.
module lc3_dmem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    lc3_dmem_responder_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;
    localparam int unsigned DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, acc_addr;
    logic [DW-1:0] din_q, acc_din;
    logic          wr_q, acc_wr;
    logic          accept, access;
    logic [DW-1:0] dout_q;
    logic          complete_q, busy_q;
    logic [DW-1:0] mem [DEPTH];

    // Upper address bits are intentionally dropped so addresses wrap modulo DEPTH.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.D_addr[DW-1:AW];

    // Next-state logic; the access target comes straight from the inputs when LATENCY=1.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        access   = 1'b0;
        acc_addr = addr_q;
        acc_din  = din_q;
        acc_wr   = wr_q;
        case (state_q)
            IDLE: begin
                if (bus.D_macc && (bus.mem_state != 2'd3)) begin
                    accept   = 1'b1;
                    acc_addr = bus.D_addr[AW-1:0];
                    acc_din  = bus.D_Din;
                    acc_wr   = (bus.mem_state == 2'd2);
                    cnt_d    = CW'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = DONE;
                        access  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request latches and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            wr_q       <= 1'b0;
            complete_q <= 1'b0;
            busy_q     <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            complete_q <= (state_d == DONE);
            busy_q     <= (state_d != IDLE);
            if (accept) begin
                addr_q <= acc_addr;
                din_q  <= acc_din;
                wr_q   <= acc_wr;
            end
            if (access && !acc_wr) begin
                dout_q <= mem[acc_addr];
            end
        end
    end

    // Storage is not reset; a write held off by reset must never land.
    always_ff @(posedge clk) begin
        if (access && acc_wr && !rst) begin
            mem[acc_addr] <= acc_din;
        end
    end

    assign bus.D_Dout        = dout_q;
    assign bus.complete_data = complete_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_lc3_dmem_responder.sv
// Randomized self-checking bench for lc3_dmem_responder: one LATENCY=2 and one LATENCY=4 instance
// checked against an array-based reference of the memory and the expected completion timing.
module tb_lc3_dmem_responder;
    localparam int unsigned DEPTH = 256;

    logic clk = 1'b0;
    logic rst;
    logic rst4;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [15:0] ref_mem  [2][DEPTH];
    logic [15:0] ref_dout [2];
    int          lat_of   [2] = '{2, 4};

    lc3_dmem_responder_if bus();
    lc3_dmem_responder_if bus4();

    lc3_dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    lc3_dmem_responder #(.DEPTH(DEPTH), .LATENCY(4)) u_dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic cplt_of(input int b);
        return (b == 0) ? bus.complete_data : bus4.complete_data;
    endfunction

    function automatic logic busy_of(input int b);
        return (b == 0) ? bus.busy : bus4.busy;
    endfunction

    function automatic logic [15:0] dout_of(input int b);
        return (b == 0) ? bus.D_Dout : bus4.D_Dout;
    endfunction

    task automatic drive(input int b, input logic m, input logic [1:0] s,
                         input logic [15:0] a, input logic [15:0] d);
        if (b == 0) begin
            bus.D_macc = m; bus.mem_state = s; bus.D_addr = a; bus.D_Din = d;
        end else begin
            bus4.D_macc = m; bus4.mem_state = s; bus4.D_addr = a; bus4.D_Din = d;
        end
    endtask

    task automatic set_rst(input int b, input logic v);
        if (b == 0) rst = v;
        else        rst4 = v;
    endtask

    // One request issued at a negedge; garbage (g*) is driven while the request is in flight.
    task automatic do_req(input int b, input logic [1:0] ms, input logic [15:0] addr,
                          input logic [15:0] din, input logic gm, input logic [1:0] gs,
                          input logic [15:0] ga, input logic [15:0] gd);
        int   n;
        logic busy_ok;
        int   idx;
        idx = int'(addr) % DEPTH;
        drive(b, 1'b1, ms, addr, din);
        @(posedge clk);
        #1;
        drive(b, gm, gs, ga, gd);
        n = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (!busy_of(b)) busy_ok = 1'b0;
        end while (!cplt_of(b) && n < 24);
        drive(b, 1'b0, 2'd3, 16'h0, 16'h0);
        if (ms == 2'd2) ref_mem[b][idx] = din;
        else            ref_dout[b] = ref_mem[b][idx];
        check("latency", 32'(n - 1), 32'(lat_of[b]));
        check("busy_window", 32'(busy_ok), 32'(1));
        check("dout_at_done", 32'(dout_of(b)), 32'(ref_dout[b]));
        @(negedge clk);
        check("after_done", 32'({cplt_of(b), busy_of(b)}), 32'(0));
        check("dout_hold", 32'(dout_of(b)), 32'(ref_dout[b]));
    endtask

    task automatic rand_req(input int b, input logic [1:0] ms, input logic [15:0] addr,
                            input logic [15:0] din);
        do_req(b, ms, addr, din, 1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom));
    endtask

    // Accept a write, then assert reset k edges later while the access is still pending.
    task automatic reset_in_wait(input int b, input logic [15:0] addr, input logic [15:0] din,
                                 input int k);
        int hits;
        drive(b, 1'b1, 2'd2, addr, din);
        @(posedge clk);
        #1;
        drive(b, 1'b0, 2'd3, 16'h0, 16'h0);
        repeat (k) @(posedge clk);
        #3;
        set_rst(b, 1'b1);
        #1;
        check("rst_async", 32'({cplt_of(b), busy_of(b), dout_of(b)}), 32'(0));
        @(negedge clk);
        set_rst(b, 1'b0);
        ref_dout[b] = 16'h0000;
        hits = 0;
        repeat (lat_of[b] + 3) begin
            @(negedge clk);
            if (cplt_of(b) || busy_of(b)) hits++;
        end
        check("rst_abort", 32'(hits), 32'(0));
    endtask

    initial begin
        int          hits;
        int          bz;
        logic [15:0] last_addr;
        logic [15:0] a;

        drive(0, 1'b0, 2'd3, 16'h0, 16'h0);
        drive(1, 1'b0, 2'd3, 16'h0, 16'h0);
        rst  = 1'b0;
        rst4 = 1'b0;
        ref_dout[0] = 16'h0;
        ref_dout[1] = 16'h0;

        // Reset asserted mid-cycle, before any clock edge.
        #3;
        rst  = 1'b1;
        rst4 = 1'b1;
        #1;
        check("rst_outputs", 32'({bus.complete_data, bus.busy, bus.D_Dout}), 32'(0));
        check("rst_outputs4", 32'({bus4.complete_data, bus4.busy, bus4.D_Dout}), 32'(0));
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        rst4 = 1'b0;

        hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.complete_data || bus4.complete_data) hits++;
        end
        check("idle_no_pulse", 32'(hits), 32'(0));

        for (int i = 0; i < int'(DEPTH); i++) rand_req(0, 2'd2, 16'(i), 16'($urandom));

        rand_req(0, 2'd2, 16'h0012, 16'hBEEF);
        rand_req(0, 2'd0, 16'h0012, 16'h0000);
        check("beef", 32'(bus.D_Dout), 32'(16'hBEEF));

        rand_req(0, 2'd2, 16'h0005, 16'h0040);
        rand_req(0, 2'd2, 16'h0040, 16'h1234);
        rand_req(0, 2'd1, 16'h0005, 16'h0000);
        check("ldi_ptr", 32'(bus.D_Dout), 32'(16'h0040));
        rand_req(0, 2'd0, 16'h0040, 16'h0000);
        check("ldi_data", 32'(bus.D_Dout), 32'(16'h1234));

        rand_req(0, 2'd2, 16'h0103, 16'hAAAA);
        rand_req(0, 2'd0, 16'h0003, 16'h0000);
        check("wrap", 32'(bus.D_Dout), 32'(16'hAAAA));

        drive(0, 1'b1, 2'd3, 16'h0011, 16'h5A5A);
        hits = 0;
        bz = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.complete_data) hits++;
            if (bus.busy) bz++;
        end
        drive(0, 1'b0, 2'd3, 16'h0, 16'h0);
        check("idle_op_pulse", 32'(hits), 32'(0));
        check("idle_op_busy", 32'(bz), 32'(0));

        do_req(0, 2'd0, 16'h0007, 16'h0000, 1'b1, 2'd2, 16'h0009, 16'hDEAD);
        rand_req(0, 2'd0, 16'h0009, 16'h0000);

        last_addr = 16'h0;
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 3) == 0) ? last_addr : 16'($urandom);
            rand_req(0, 2'($urandom_range(0, 2)), a, 16'($urandom));
            last_addr = a;
        end

        reset_in_wait(0, 16'h0021, 16'h7777, 1);
        rand_req(0, 2'd0, 16'h0021, 16'h0000);

        rand_req(1, 2'd2, 16'h0003, 16'h0001);
        reset_in_wait(1, 16'h0003, 16'h5555, 2);
        rand_req(1, 2'd0, 16'h0003, 16'h0000);
        check("rst_mid_write", 32'(bus4.D_Dout), 32'(16'h0001));
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom_range(0, 7));
            rand_req(1, 2'($urandom_range(0, 2)), a, 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
